// File: rtl/fetch_decode.sv
// fetch_decode: front-end stage directly upstream of bus_control.
// Fetches one 8-bit instruction word at the current PC, latches it into the
// instruction register and decodes it into a one-hot instruction_en vector
// plus a 3-bit reg_num. Both are held for the whole execution of the
// instruction while exec_cycle counts execution cycles. A PC increment is
// requested when bus_control reports completion, or when the watchdog
// forces it.
//
// Ports:
//   clk            in   system clock, all state on rising edge
//   rst            in   synchronous active-high reset
//   pc             in   current PC value
//   imem_addr      out  instruction memory address (= pc)
//   imem_rdata     in   instruction word, valid 1 cycle after imem_addr
//   halt           in   stop after the current instruction completes
//   instr_done     in   last cycle of the current instruction (EXEC only)
//   pc_loaded      in   PC written this cycle, suppresses pc_inc (EXEC only)
//   instruction_en out  one-hot decoded opcode, zero outside EXEC
//   reg_num        out  instruction bits [2:0], zero outside EXEC
//   exec_cycle     out  0-based cycle index within the instruction
//   pc_inc         out  single-cycle PC increment request
//   illegal_op     out  single-cycle pulse: opcode out of range
//   exec_timeout   out  single-cycle pulse: watchdog forced completion
//   halted         out  high while in HALT
module fetch_decode #(
  parameter int unsigned ISA_INSTRUCTION_COUNT = 16,
  parameter int unsigned MAX_EXEC_CYCLES       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       pc,
  output logic [7:0]                       imem_addr,
  input  logic [7:0]                       imem_rdata,
  input  logic                             halt,
  input  logic                             instr_done,
  input  logic                             pc_loaded,
  output logic [ISA_INSTRUCTION_COUNT-1:0] instruction_en,
  output logic [2:0]                       reg_num,
  output logic [1:0]                       exec_cycle,
  output logic                             pc_inc,
  output logic                             illegal_op,
  output logic                             exec_timeout,
  output logic                             halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] LAST_CYCLE = 2'(MAX_EXEC_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_ir;
  logic [1:0] r_exec_cycle;
  logic       w_legal;
  logic       w_in_exec;

  assign imem_addr = pc;
  assign w_in_exec = (r_state == S_EXEC);
  assign w_legal   = (32'(imem_rdata[7:3]) < ISA_INSTRUCTION_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_ir         <= '0;
      r_exec_cycle <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_WAIT) begin
        r_ir         <= imem_rdata;
        r_exec_cycle <= '0;
      end else if (w_in_exec && (w_next_state == S_EXEC)) begin
        r_exec_cycle <= r_exec_cycle + 2'd1;
      end
    end
  end

  // Pulses are decoded from the registered state so they line up with the
  // cycle that leaves the state; reset masks them so an abandoned
  // instruction never requests a PC increment.
  always_comb begin
    w_next_state = r_state;
    pc_inc       = 1'b0;
    illegal_op   = 1'b0;
    exec_timeout = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = halt ? S_HALT : S_WAIT;
      S_WAIT: begin
        if (w_legal) begin
          w_next_state = S_EXEC;
        end else begin
          illegal_op   = 1'b1;
          pc_inc       = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_EXEC: begin
        if (instr_done) begin
          pc_inc       = ~pc_loaded;
          w_next_state = S_FETCH;
        end else if (r_exec_cycle == LAST_CYCLE) begin
          exec_timeout = 1'b1;
          pc_inc       = ~pc_loaded;
          w_next_state = S_FETCH;
        end
      end
      S_HALT: begin
        if (!halt) w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
    if (rst) begin
      pc_inc       = 1'b0;
      illegal_op   = 1'b0;
      exec_timeout = 1'b0;
    end
  end

  always_comb begin
    instruction_en = '0;
    for (int unsigned i = 0; i < ISA_INSTRUCTION_COUNT; i++) begin
      instruction_en[i] = w_in_exec && (r_ir[7:3] == 5'(i));
    end
  end

  assign reg_num    = w_in_exec ? r_ir[2:0] : 3'd0;
  assign exec_cycle = w_in_exec ? r_exec_cycle : 2'd0;
  assign halted     = (r_state == S_HALT);

endmodule
